// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: registered pad drive, per-pin synchroniser and debounce,
// edge events into sticky write-1-to-clear status, and one masked registered interrupt.
module gpio_port_ctrl #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] out_data_i,
    input  logic [WIDTH-1:0] out_en_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    input  logic [WIDTH-1:0] status_clr_i,
    input  logic [WIDTH-1:0] gpio_pin_i,
    output logic [WIDTH-1:0] gpio_pin_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic [WIDTH-1:0] in_data_o,
    output logic [WIDTH-1:0] status_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_pin_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_filt;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_status;
    logic             r_irq;

    logic [CNT_W-1:0] w_cnt_next [WIDTH];
    logic [WIDTH-1:0] w_filt_next;
    logic [WIDTH-1:0] w_update;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_status_next;
    logic             w_irq_next;

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any return
    // to the filtered level throws the partial count away.
    always_comb begin
        w_filt_next = r_filt;
        w_update    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (r_sync2[i] == r_filt[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_next[i]  = '0;
                w_filt_next[i] = r_sync2[i];
                w_update[i]    = 1'b1;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Enables are only looked at in the update cycle; set beats clear.
    always_comb begin
        w_rise        = w_update & w_filt_next & rise_en_i;
        w_fall        = w_update & ~w_filt_next & fall_en_i;
        w_event       = w_rise | w_fall;
        w_status_next = w_event | (r_status & ~status_clr_i);
        w_irq_next    = |(w_status_next & irq_mask_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pin_out <= '0;
            r_oe      <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_filt    <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pin_out <= out_data_i;
            r_oe      <= out_en_i;
            r_sync1   <= gpio_pin_i;
            r_sync2   <= r_sync1;
            r_filt    <= w_filt_next;
            r_status  <= w_status_next;
            r_irq     <= w_irq_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign gpio_pin_o = r_pin_out;
    assign gpio_oe_o  = r_oe;
    assign in_data_o  = r_filt;
    assign status_o   = r_status;
    assign irq_o      = r_irq;

endmodule

// File: doc/gpio_port_ctrl.md
# gpio_port_ctrl

Parametrised GPIO port controller: `WIDTH` bidirectional pins with registered output drive and per-pin output enable. Each input goes through a two-flop synchroniser and a per-pin debounce filter, then a per-pin rising/falling edge detector that sets sticky, write-1-to-clear status bits. The block produces one masked, registered interrupt. It sits between the pad ring and the peripheral register file, and the GPIO UVC drives and monitors its pin side.

## Interface
Parameters:
- `WIDTH`, 32: number of pins, range 1..32.
- `DEBOUNCE_CYCLES`, 1: consecutive stable cycles required before the filtered input changes, range 1..65535. A value of 1 means no filtering.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `out_data_i`  in  WIDTH  requested pin output values.
- `out_en_i`  in  WIDTH  requested per-pin output enables (1 = drive).
- `rise_en_i`  in  WIDTH  enables rising-edge events per pin.
- `fall_en_i`  in  WIDTH  enables falling-edge events per pin.
- `irq_mask_i`  in  WIDTH  per-pin interrupt enable (1 = contributes to `irq_o`).
- `status_clr_i`  in  WIDTH  one-cycle write-1-to-clear strobe for status bits.
- `gpio_pin_i`  in  WIDTH  asynchronous pad inputs.
- `gpio_pin_o`  out  WIDTH  registered pad output values.
- `gpio_oe_o`  out  WIDTH  registered pad output enables.
- `in_data_o`  out  WIDTH  debounced, synchronised input values.
- `status_o`  out  WIDTH  sticky edge-event status.
- `irq_o`  out  1  registered OR of `status_o & irq_mask_i`.

## Operation
- **Output path**
  - `gpio_pin_o <= out_data_i` and `gpio_oe_o <= out_en_i` on every edge.
  - No other logic on this path.
- **Input synchroniser**
  - `sync1 <= gpio_pin_i`, then `sync2 <= sync1`.
  - Applies to every pin, regardless of `gpio_oe_o`. Driven pins loop back.
- **Debounce**, per pin. State is a counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, and a register `filt`.
  - If `sync2 == filt`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `filt <= sync2` and `cnt <= 0`. This is the update event.
  - Else: `cnt <= cnt+1`.
  - Any mismatch run shorter than `DEBOUNCE_CYCLES` resets the counter and is discarded.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
  - `in_data_o = filt`.
- **Edge detect**, evaluated in the cycle of an update event.
  - A rise (`filt` 0→1) with `rise_en_i` set produces an event.
  - A fall (`filt` 1→0) with `fall_en_i` set produces an event.
  - Both enables set gives any-edge detection.
  - Enable inputs are sampled in the update cycle only. Changing them later does not retro-create events.
- **Status**, per bit.
  - `status <= event | (status & ~status_clr_i)`.
  - If set and clear occur in the same cycle, set wins.
  - Clearing an already-clear bit has no effect.
- **Interrupt**
  - `irq_o <= |(status_next & irq_mask_i)`, i.e. computed from the value `status` takes on the same edge.
  - Masking does not affect `status`. Unmasking a pending bit raises `irq_o` on the next edge.
- **Reset**, while `rst_i` is high at an edge:
  - `gpio_pin_o`, `gpio_oe_o`, `sync1`, `sync2`, `filt`, `cnt`, `status_o` and `irq_o` all go to 0.
  - No events are generated.
  - Reset asserted mid-debounce discards the partial count.
  - A pin held high through reset release produces a rise event on its first update. Software clears it.

## Timing
- **Output latency:** 1 cycle from `out_*_i` to `gpio_pin_o` / `gpio_oe_o`.
- **Input latency.** Pin stable from before edge k, with `filt` differing:
  - `sync1` at k, `sync2` at k+1.
  - `filt`, `in_data_o` and `status_o` update at edge k+1+`DEBOUNCE_CYCLES`.
  - `irq_o` updates at the same edge.
  - With `DEBOUNCE_CYCLES=1`, `in_data_o` changes 2 cycles after the first sampling edge.
- **Clear latency:** a `status_clr_i` pulse at edge m clears `status_o` at m. `irq_o` deasserts at m if no other masked bit is pending.
- **Throughput:** a pin can generate an event at most once per `DEBOUNCE_CYCLES` cycles.
- **Independence:** pins are independent. Simultaneous events on several pins set all corresponding bits in the same cycle.

## Test plan
- **Reset values:** assert `rst_i` for 3 cycles with pins at 0 -> all outputs 0. Set `out_data_i=0xA5`, `out_en_i=0x0F` -> `gpio_pin_o=0xA5` and `gpio_oe_o=0x0F` one cycle later.
- **Rise with debounce.** `WIDTH=8`, `DEBOUNCE_CYCLES=4`, `rise_en_i[3]=1`, `irq_mask_i[3]=1`. Stimulus: pin 3 goes 0→1 before edge k. Required: `in_data_o[3]`, `status_o[3]` and `irq_o` all become 1 at edge k+5.
- **Glitch rejection.** `DEBOUNCE_CYCLES=4`. Stimulus: pin 0 high for 3 cycles, then low. Required: `in_data_o[0]` stays 0 and `status_o` stays 0.
- **Any-edge plus mask.** Stimulus: `rise_en_i[1]=fall_en_i[1]=1`, `irq_mask_i[1]=0`, pin 1 pulsed 1 then 0, each level held ≥ D+2 cycles. Required: `status_o[1]` set after the rise and `irq_o` stays 0. Then unmask -> `irq_o=1` next cycle.
- **Clear/set collision.** Stimulus: `status_clr_i[2]` pulsed in the same cycle as a new pin-2 event. Required: `status_o[2]` remains 1. A clear in a cycle with no event -> `status_o[2]=0` and `irq_o=0`.
- **Mid-operation reset.** Stimulus: `rst_i` pulsed during a debounce count. Required: count discarded and outputs 0. After release with the pin held high and `rise_en_i` set, a rise event is reported D+2 cycles later.
